// File: rtl/hash_sample_seq.sv
// hash_sample_seq: sequences squeezed hash words into per-sample advance
// strobes for the downstream address generator. One word carries LANES
// 16-bit samples; a run issues exactly the sample total for the latched
// mode/level, then pulses done.
module hash_sample_seq #(
    parameter int LANES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] mode_in,
    input  logic [1:0] level_in,
    input  logic       abort,
    input  logic       hash_valid,
    output logic       hash_ready,
    output logic       addr_clr,
    output logic       add_en,
    output logic [2:0] mode,
    output logic [1:0] level,
    output logic [2:0] sample_sel,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        WAIT,
        ISSUE,
        FIN
    } state_t;

    state_t      state_q, state_d;
    logic [13:0] remaining_q, remaining_d;
    logic [2:0]  lane_q, lane_d;
    logic [2:0]  mode_q, mode_d;
    logic [1:0]  level_q, level_d;
    logic        err_q, err_d;

    logic        mode_legal;
    logic [13:0] n_val;
    logic [13:0] total;

    // Sample total for the request presented on mode_in/level_in.
    always_comb begin
        mode_legal = (mode_in == 3'b000) || (mode_in == 3'b001) ||
                     (mode_in == 3'b100) || (mode_in == 3'b101);
        case (level_in)
            2'b01:   n_val = 14'd1344;
            2'b10:   n_val = 14'd976;
            default: n_val = 14'd640;
        endcase
        case (mode_in)
            3'b001:  total = 14'd64;
            3'b100:  total = n_val << 2;
            default: total = n_val << 3;
        endcase
    end

    // State and run registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            lane_q      <= '0;
            mode_q      <= '0;
            level_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            lane_q      <= lane_d;
            mode_q      <= mode_d;
            level_q     <= level_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic; abort overrides every state, including a start in IDLE.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        lane_d      = lane_q;
        mode_d      = mode_q;
        level_d     = level_q;
        err_d       = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (mode_legal && (level_in != 2'b00)) begin
                            mode_d      = mode_in;
                            level_d     = level_in;
                            remaining_d = total;
                            state_d     = CLR;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                CLR: state_d = WAIT;
                WAIT: begin
                    if (hash_valid) begin
                        lane_d  = '0;
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    lane_d      = lane_q + 3'd1;
                    remaining_d = remaining_q - 14'd1;
                    // Last sample wins over end-of-word: unused lanes are dropped.
                    if (remaining_q == 14'd1) begin
                        state_d = FIN;
                    end else if (lane_q == 3'(LANES - 1)) begin
                        state_d = WAIT;
                    end
                end
                FIN: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs decode from state; rst forces them all low immediately.
    always_comb begin
        hash_ready = 1'b0;
        addr_clr   = 1'b0;
        add_en     = 1'b0;
        sample_sel = '0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        mode       = '0;
        level      = '0;
        if (!rst) begin
            busy       = (state_q != IDLE);
            addr_clr   = (state_q == CLR);
            hash_ready = (state_q == WAIT) && !abort;
            add_en     = (state_q == ISSUE) && !abort;
            sample_sel = add_en ? lane_q : 3'b000;
            done       = (state_q == FIN) && !abort;
            err        = err_q;
            mode       = mode_q;
            level      = level_q;
        end
    end

endmodule

// File: doc/hash_sample_seq.md
HASH_SAMPLE_SEQ -- requirements
Module: hash_sample_seq

Interface
REQ-001 The block SHALL have parameter LANES, default 4, meaning 16-bit samples per squeezed hash word; legal values are 1, 2, 4 and 8.
REQ-002 Port clk SHALL be an input, 1 bit: the single clock, with all logic on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit: reset, synchronous and active-high.
REQ-004 Port start SHALL be an input, 1 bit: a one-cycle request to begin a sampling run.
REQ-005 Port mode_in SHALL be an input, 3 bits: the matrix type, 000 S/S'/E', 001 E'', 100 B, 101 B'.
REQ-006 Port level_in SHALL be an input, 2 bits: the security level, 01 n=1344, 10 n=976, 11 n=640, 00 illegal.
REQ-007 Port abort SHALL be an input, 1 bit: cancels the run in progress.
REQ-008 Port hash_valid SHALL be an input, 1 bit: the squeeze core presents a word.
REQ-009 Port hash_ready SHALL be an output, 1 bit: the block accepts the word presented.
REQ-010 Port addr_clr SHALL be an output, 1 bit: clear pulse to the downstream address generator.
REQ-011 Port add_en SHALL be an output, 1 bit: one-cycle advance strobe to the address generator, one per sample.
REQ-012 Port mode SHALL be an output, 3 bits: the latched mode_in, held for the whole run.
REQ-013 Port level SHALL be an output, 2 bits: the latched level_in, held for the whole run.
REQ-014 Port sample_sel SHALL be an output, 3 bits: the lane of the captured word whose sample is being written this cycle.
REQ-015 Port busy SHALL be an output, 1 bit: high in every state except IDLE.
REQ-016 Port done SHALL be an output, 1 bit: a one-cycle pulse when a run completes.
REQ-017 Port err SHALL be an output, 1 bit: a one-cycle pulse when start carries an illegal mode or level.

Function
REQ-018 The FSM SHALL have exactly five states: IDLE, CLR, WAIT, ISSUE and FIN.
REQ-019 In IDLE, start with a legal mode_in and a nonzero level_in SHALL do all of the following on the same edge: latch mode and level, load remaining with the sample total, and move to CLR.
REQ-020 In IDLE, start with an illegal mode_in (010, 011, 110 or 111) or with level_in=00 SHALL pulse err the next cycle and leave the FSM in IDLE.
REQ-021 The sample total SHALL be 8n for modes 000 and 101, 4n for mode 100, and 64 for mode 001.
REQ-022 remaining SHALL be 14 bits wide, with a maximum of 10752.
REQ-023 CLR SHALL last one cycle, assert addr_clr=1 for that cycle, and then move to WAIT.
REQ-024 In WAIT, hash_ready SHALL be 1.
REQ-025 In WAIT, hash_valid=1 SHALL complete the transfer, set lane to 0, and move to ISSUE.
REQ-026 hash_ready SHALL be 0 in every state other than WAIT.
REQ-027 In ISSUE, every cycle SHALL assert add_en=1, drive sample_sel=lane, increment lane, and decrement remaining.
REQ-028 When remaining=1 in ISSUE, that cycle's add_en SHALL be the last of the run and the FSM SHALL move to FIN.
REQ-029 Otherwise, when lane=LANES-1 in ISSUE, the FSM SHALL return to WAIT.
REQ-030 Otherwise the FSM SHALL stay in ISSUE.
REQ-031 When the total is not a multiple of LANES, the unused lanes of the final word SHALL be discarded.
REQ-032 The number of add_en pulses in a run SHALL equal the sample total exactly.
REQ-033 FIN SHALL last one cycle, assert done=1 for that cycle, and then move to IDLE.
REQ-034 mode and level SHALL hold their values through FIN and while in IDLE until the next accepted start.
REQ-035 start SHALL be ignored whenever busy=1.
REQ-036 abort=1 in any state SHALL move the FSM to IDLE on the next edge and force add_en=0 and hash_ready=0 in that cycle.
REQ-037 An aborted run SHALL NOT pulse done.
REQ-038 When abort and start are both high in IDLE, abort SHALL win and start SHALL be ignored.
REQ-039 A hash_valid that falls in a cycle where hash_ready=0 SHALL NOT be consumed.
REQ-040 Latency from an accepted start to addr_clr SHALL be 1 cycle.
REQ-041 Latency from a WAIT handshake to the first add_en of that word SHALL be 1 cycle.
REQ-042 With hash_valid held at 1, a full word SHALL take LANES+1 cycles.

Reset
REQ-043 While rst=1, on every edge the FSM SHALL go to IDLE and remaining and lane SHALL be set to 0.
REQ-044 While rst=1, hash_ready, addr_clr, add_en, busy, done and err SHALL be 0, sample_sel SHALL be 000, mode SHALL be 000 and level SHALL be 00.
REQ-045 Reset asserted mid-run SHALL discard the run with no done pulse.
REQ-046 rst SHALL take priority over abort and start.

Verification
REQ-047 Scenario: LANES=4, mode 000, level 11, hash_valid held at 1 -> 5120 add_en pulses, 1280 handshakes, one addr_clr, then done once, with sample_sel cycling 0,1,2,3.
REQ-048 Scenario: mode 001, level 01 -> exactly 64 add_en pulses and done 1 cycle after the last one.
REQ-049 Scenario: mode 100, level 10, hash_valid toggled randomly -> 3904 add_en pulses, add_en never asserted in WAIT, and no word lost or duplicated.
REQ-050 Scenario: start with mode 011, then start with level 00 -> err pulses each time, busy stays 0, add_en stays 0.
REQ-051 Scenario: abort raised in ISSUE after 100 samples -> idle next cycle, no done; a following start reruns with a fresh addr_clr and the full count.
REQ-052 Scenario: rst asserted mid-run and start pulsed while busy -> all outputs 0 on the next edge, and the start pulsed while busy is ignored.
